// File: rtl/clic_gateway.sv
// Per-source interrupt gateway: synchronizes raw lines, applies polarity, latches
// edges or passes levels, and drives the registered pending vector to the arbiter.
module clic_gateway #(
    parameter int N_SOURCE    = 256,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N_SOURCE-1:0] intr_src_i,
    input  logic [N_SOURCE-1:0] le_i,
    input  logic [N_SOURCE-1:0] pol_i,
    input  logic [N_SOURCE-1:0] claim_i,
    input  logic [N_SOURCE-1:0] ip_we_i,
    input  logic [N_SOURCE-1:0] ip_wdata_i,
    output logic [N_SOURCE-1:0] ip_o
);

    logic [N_SOURCE-1:0] s_raw;
    logic [N_SOURCE-1:0] prev_q;
    logic [N_SOURCE-1:0] edge_det;
    logic [N_SOURCE-1:0] lvl;
    logic [N_SOURCE-1:0] ip_edge_d;
    logic [N_SOURCE-1:0] ip_d;
    logic [N_SOURCE-1:0] ip_q;

    if (SYNC_STAGES == 0) begin : g_bypass
        assign s_raw = intr_src_i;
    end else begin : g_sync
        logic [N_SOURCE-1:0] sync_q [SYNC_STAGES];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < SYNC_STAGES; i++) begin
                    sync_q[i] <= '0;
                end
            end else begin
                sync_q[0] <= intr_src_i;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_q[i] <= sync_q[i-1];
                end
            end
        end

        assign s_raw = sync_q[SYNC_STAGES-1];
    end

    // prev_q is polarity-independent, so a pol change alone never creates an edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= '0;
        end else begin
            prev_q <= s_raw;
        end
    end

    always_comb begin
        edge_det = (~pol_i & s_raw & ~prev_q) | (pol_i & ~s_raw & prev_q);
        lvl      = s_raw ^ pol_i;
        // edge beats software write, which beats claim
        ip_edge_d = edge_det
                  | (~edge_det & ip_we_i & ip_wdata_i)
                  | (~edge_det & ~ip_we_i & ~claim_i & ip_q);
        ip_d      = (le_i & ip_edge_d) | (~le_i & lvl);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ip_q <= '0;
        end else begin
            ip_q <= ip_d;
        end
    end

    assign ip_o = ip_q;

endmodule

// File: tb/tb_clic_gateway.sv
// Bench for clic_gateway: directed vector table, hand sequences for reset corners,
// and randomized traffic checked against a per-source behavioural model.
module tb_clic_gateway;

    localparam int N    = 16;
    localparam int SYNC = 2;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] intr, le, pol, claim, we, wd;
    logic [N-1:0] ip;

    int n_checks = 0;
    int n_err    = 0;

    // model: input samples taken at previous edges (index 0 = most recent)
    logic [N-1:0] samp [SYNC+1];
    logic [N-1:0] m_ip;

    typedef struct {
        logic [N-1:0] intr, le, pol, claim, we, wd, exp_ip;
    } vec_t;

    vec_t tbl [36];

    clic_gateway #(.N_SOURCE(N), .SYNC_STAGES(SYNC)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .intr_src_i (intr),
        .le_i       (le),
        .pol_i      (pol),
        .claim_i    (claim),
        .ip_we_i    (we),
        .ip_wdata_i (wd),
        .ip_o       (ip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: ip_o=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k <= SYNC; k++) samp[k] = '0;
        m_ip = '0;
    endtask

    // Applies the pending-bit rules to what the synchronizer shows at this edge.
    task automatic model_edge();
        logic [N-1:0] s, p;
        bit hit;
        s = samp[SYNC-1];
        p = samp[SYNC];
        for (int i = 0; i < N; i++) begin
            hit = pol[i] ? (!s[i] && p[i]) : (s[i] && !p[i]);
            if (!le[i])         m_ip[i] = pol[i] ? !s[i] : s[i];
            else if (hit)       m_ip[i] = 1'b1;
            else if (we[i])     m_ip[i] = wd[i];
            else if (claim[i])  m_ip[i] = 1'b0;
        end
        for (int k = SYNC; k > 0; k--) samp[k] = samp[k-1];
        samp[0] = intr;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic vec_t mk(input logic [N-1:0] i_, l_, p_, c_, w_, d_, e_);
        vec_t v;
        v.intr = i_; v.le = l_; v.pol = p_; v.claim = c_; v.we = w_; v.wd = d_; v.exp_ip = e_;
        return v;
    endfunction

    initial begin
        localparam logic [N-1:0] LE  = 16'hFFF7;
        localparam logic [N-1:0] POL = 16'h0208;
        localparam logic [N-1:0] PT  = 16'h0008;
        logic [N-1:0] r;

        //            intr      le    pol   claim    we       wd       exp
        tbl[0]  = mk(16'h0208, LE, POL, 16'h0,  16'h0,  16'h0,  16'h0008);
        tbl[1]  = mk(16'h0208, LE, POL, 16'h0,  16'h0,  16'h0,  16'h0008);
        tbl[2]  = mk(16'h0208, LE, POL, 16'h0,  16'h0,  16'h0,  16'h0000);
        tbl[3]  = mk(16'h0208, LE, POL, 16'h0,  16'h0,  16'h0,  16'h0000);
        tbl[4]  = mk(16'h0200, LE, POL, 16'h0,  16'h0,  16'h0,  16'h0000);
        tbl[5]  = mk(16'h0200, LE, POL, 16'h0,  16'h0,  16'h0,  16'h0000);
        tbl[6]  = mk(16'h0200, LE, POL, 16'h0,  16'h0,  16'h0,  16'h0008);
        tbl[7]  = mk(16'h0200, LE, POL, 16'h8,  16'h8,  16'h0,  16'h0008);
        tbl[8]  = mk(16'h0208, LE, POL, 16'h0,  16'h0,  16'h0,  16'h0008);
        tbl[9]  = mk(16'h0208, LE, POL, 16'h0,  16'h0,  16'h0,  16'h0008);
        tbl[10] = mk(16'h0208, LE, POL, 16'h0,  16'h0,  16'h0,  16'h0000);
        tbl[11] = mk(16'h0008, LE, POL, 16'h0,  16'h0,  16'h0,  16'h0000);
        tbl[12] = mk(16'h0008, LE, POL, 16'h0,  16'h0,  16'h0,  16'h0000);
        tbl[13] = mk(16'h0008, LE, POL, 16'h0,  16'h0,  16'h0,  16'h0200);
        tbl[14] = mk(16'h0008, LE, PT,  16'h0,  16'h0,  16'h0,  16'h0200);
        tbl[15] = mk(16'h0008, LE, POL, 16'h0,  16'h0,  16'h0,  16'h0200);
        tbl[16] = mk(16'h0008, LE, POL, 16'h200,16'h0,  16'h0,  16'h0000);
        tbl[17] = mk(16'h0008, LE, PT,  16'h0,  16'h0,  16'h0,  16'h0000);
        tbl[18] = mk(16'h0008, LE, POL, 16'h0,  16'h0,  16'h0,  16'h0000);
        tbl[19] = mk(16'h0088, LE, POL, 16'h0,  16'h0,  16'h0,  16'h0000);
        tbl[20] = mk(16'h0008, LE, POL, 16'h0,  16'h0,  16'h0,  16'h0000);
        tbl[21] = mk(16'h0008, LE, POL, 16'h0,  16'h0,  16'h0,  16'h0080);
        tbl[22] = mk(16'h0008, LE, POL, 16'h0,  16'h0,  16'h0,  16'h0080);
        tbl[23] = mk(16'h0008, LE, POL, 16'h0,  16'h0,  16'h0,  16'h0080);
        tbl[24] = mk(16'h0008, LE, POL, 16'h80, 16'h0,  16'h0,  16'h0000);
        tbl[25] = mk(16'h0088, LE, POL, 16'h0,  16'h0,  16'h0,  16'h0000);
        tbl[26] = mk(16'h0008, LE, POL, 16'h0,  16'h0,  16'h0,  16'h0000);
        tbl[27] = mk(16'h0008, LE, POL, 16'h0,  16'h0,  16'h0,  16'h0080);
        tbl[28] = mk(16'h0088, LE, POL, 16'h0,  16'h0,  16'h0,  16'h0080);
        tbl[29] = mk(16'h0008, LE, POL, 16'h0,  16'h0,  16'h0,  16'h0080);
        tbl[30] = mk(16'h0008, LE, POL, 16'h80, 16'h0,  16'h0,  16'h0080);
        tbl[31] = mk(16'h0008, LE, POL, 16'h80, 16'h0,  16'h0,  16'h0000);
        tbl[32] = mk(16'h0008, LE, POL, 16'h0,  16'h1000,16'h1000,16'h1000);
        tbl[33] = mk(16'h0008, LE, POL, 16'h1000,16'h1000,16'h0, 16'h0000);
        tbl[34] = mk(16'h0008, LE, POL, 16'h1000,16'h1000,16'h1000,16'h1000);
        tbl[35] = mk(16'h0008, LE, POL, 16'h1000,16'h0, 16'h0,  16'h0000);

        // reset with a rising-edge source already high
        rst_n = 1'b0;
        intr = 16'h0020; le = '1; pol = '0; claim = '0; we = '0; wd = '0;
        model_reset();
        #2 check("reset_state", ip, 16'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick(); check("rst_edge_lat1", ip, 16'h0);
        tick(); check("rst_edge_lat2", ip, 16'h0);
        tick(); check("rst_edge_lat3", ip, 16'h0020);
        claim = 16'h0020;
        tick(); check("rst_edge_claim", ip, 16'h0);
        claim = '0; intr = '0;
        for (int k = 0; k < 4; k++) begin
            tick(); check("idle_after_claim", ip, 16'h0);
        end

        for (int k = 0; k < 36; k++) begin
            intr = tbl[k].intr; le = tbl[k].le; pol = tbl[k].pol;
            claim = tbl[k].claim; we = tbl[k].we; wd = tbl[k].wd;
            tick();
            check($sformatf("vec%0d", k), ip, tbl[k].exp_ip);
            check($sformatf("vec%0d_model", k), ip, m_ip);
        end

        // randomized traffic with occasional mid-run resets
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) intr = N'($urandom());
            if ($urandom_range(0, 40) == 0) le = N'($urandom());
            if ($urandom_range(0, 40) == 0) pol = N'($urandom());
            claim = ($urandom_range(0, 2) == 0) ? N'(1) << $urandom_range(0, N-1) : '0;
            r  = N'($urandom());
            we = r & N'($urandom()) & N'($urandom());
            wd = N'($urandom());
            if ($urandom_range(0, 400) == 0) begin
                rst_n = 1'b0;
                #1 check("midrun_reset", ip, 16'h0);
                model_reset();
                #1 rst_n = 1'b1;
            end
            tick();
            check("random", ip, m_ip);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/clic_gateway.md
# clic_gateway

Per-source interrupt gateway placed directly upstream of the CLIC target arbiter. It synchronizes raw interrupt lines and applies trigger polarity. For edge-triggered sources it detects edges and latches them; for level-triggered sources it passes the level through. It drives the registered pending vector (`ip_o`) consumed by the arbiter. It clears latched edge pendings on the arbiter's one-cycle claim pulse or on software writes to `clicintip`.

## Interface
- `N_SOURCE`, default 256: number of interrupt sources, ≥2.
- `SYNC_STAGES`, default 2: synchronizer depth on `intr_src_i`.
  - 0: bypass, for already-synchronous sources.
  - Otherwise ≥2.
- `clk_i`  in  1  clock. One clock domain.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `intr_src_i`  in  N_SOURCE  raw interrupt lines, possibly asynchronous.
- `le_i`  in  N_SOURCE  trigger type per source: 1 = edge-triggered, 0 = level-triggered. Same encoding the arbiter uses.
- `pol_i`  in  N_SOURCE  trigger polarity per source: 0 = rising edge / active-high; 1 = falling edge / active-low.
- `claim_i`  in  N_SOURCE  one-cycle claim pulse from the arbiter, at most one bit set.
- `ip_we_i`  in  N_SOURCE  software write strobe to the pending bit, one cycle per write.
- `ip_wdata_i`  in  N_SOURCE  software write data for pending bits.
- `ip_o`  out  N_SOURCE  registered pending vector to the arbiter. Reset 0.

## Operation
- **Synchronizer**
  - Per source, a chain of `SYNC_STAGES` flops, all reset 0. Output is `s_raw`.
  - With `SYNC_STAGES`=0, `s_raw = intr_src_i`.
- **Previous-sample register `prev_q`**
  - Per source, reset 0, updated every cycle with `s_raw`.
- **Edge detect**
  - `rise = ~pol & s_raw & ~prev_q`.
  - `fall = pol & ~s_raw & prev_q`.
  - `edge = rise | fall`.
  - Because `prev_q` resets to 0:
    - A rising-polarity source already high after reset produces one edge on its first synchronized sample.
    - A falling-polarity source produces no edge until it has been sampled high.
- **Level value:** `lvl = s_raw ^ pol`.
- **Pending register `ip_q` (drives `ip_o`)**, next value per source:
  - Level mode (`le`=0): `ip_q <= lvl`. `ip_we_i`, `ip_wdata_i` and `claim_i` are ignored. Level pendings clear only when the source deasserts.
  - Edge mode (`le`=1), priority high to low:
    1. `edge` → 1.
    2. `ip_we` → `ip_wdata`.
    3. `claim` → 0.
    4. Otherwise hold.
- **Simultaneous events:** a new edge always wins over a claim or a software write in the same cycle, so no edge is lost. A software write wins over a claim.
- **Runtime configuration changes:**
  - Edge→level: `ip_q` tracks `lvl` from the next edge onward.
  - Level→edge: `ip_q` holds its current value until the next set/clear event.
  - A `pol_i` change is not an edge. Edge detection uses `s_raw`/`prev_q`, which are independent of `pol_i`. A pol change can, however, satisfy the new-polarity condition on the next real transition.
- `claim_i` with multiple bits set is illegal. The block still clears each claimed edge-mode bit independently (no dependency between sources).

## Timing
- **Reset:** all synchronizer, `prev_q` and `ip_q` flops are 0; `ip_o` = 0.
- **Source-to-`ip_o` latency**, from the first clock edge at which `intr_src_i` is sampled asserted:
  - `ip_o` reflects it after `SYNC_STAGES`+1 clock edges.
  - Default: 3 edges. `SYNC_STAGES`=0: 1 edge.
  - Same latency for edge and level mode.
- **Claim-to-clear:** `claim_i` high in cycle t → `ip_o` low from cycle t+1, unless an edge is detected in cycle t.
- **Software write:** `ip_we_i` in cycle t → `ip_o = ip_wdata_i` from cycle t+1 (edge mode).
- **Minimum pulse width:**
  - Edge sources: input must be held ≥1 clock period plus setup to guarantee detection.
  - A pulse narrower than this may be missed. It is never double-counted.
- **Back-to-back edges:** edges while `ip_q`=1 are absorbed. Pending is a single bit, not a counter.
- **Reset mid-operation:** asynchronous clear of all state; no pending survives; first post-reset behaviour as above.
- `ip_o` is a pure flop output with no combinational path from any input.

## Test plan
- **Reset/edge latency:** `SYNC_STAGES`=2, reset asserted with `intr_src_i[5]`=1, `le[5]`=1, `pol[5]`=0; release → `ip_o[5]`=1 after exactly 3 edges; all other bits 0 throughout.
- **Edge latch/claim:** pulse `intr_src_i[7]` high for 1 cycle (`le`=1, `pol`=0) → `ip_o[7]` rises 3 edges later and stays 1. `claim_i[7]` for 1 cycle → `ip_o[7]`=0 next cycle.
- **Edge beats claim:** a rising edge reaches `s_raw[7]` in the same cycle as `claim_i[7]` → `ip_o[7]` stays 1. A second claim → 0.
- **Level mode:** `le[3]`=0, `pol[3]`=1, source driven 0 → `ip_o[3]`=1 after 3 edges. Then:
  - `claim_i[3]` and `ip_we_i[3]`/`wdata`=0 → no effect.
  - Source driven 1 → `ip_o[3]`=0 after 3 edges.
- **Falling edge/polarity:** `pol[9]`=1, `le[9]`=1, source 1→0 → `ip_o[9]`=1. Toggling `pol[9]` with a static source → no new edge.
- **Software writes:** edge-mode source 12, `ip_we`/`wdata`=1 → `ip_o[12]`=1 next cycle. Write 0 in the same cycle as `claim_i[12]` → 0. Write 1 in the same cycle as `claim_i[12]` → 1 (write beats claim).
